dual_port_ram_arbiter: RTL and testbench



---
 rtl/dual_port_ram_arbiter.sv | 117 +++++++++++
 tb/tb_dual_port_ram_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a 1-cycle-latency dual-port RAM.
// One command (read or write) is accepted per cycle. A single pending read
// result is tracked; while it is backpressured, reads are held off so the
// RAM read register keeps its data. Writes keep flowing.
module dual_port_ram_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int BYTE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0 command
  input  logic                  cmd0_valid,
  output logic                  cmd0_ready,
  input  logic                  cmd0_write,
  input  logic [ADDR_WIDTH-1:0] cmd0_addr,
  input  logic [DATA_WIDTH-1:0] cmd0_wdata,
  input  logic [BYTE_WIDTH-1:0] cmd0_wstrb,
  // requester 1 command
  input  logic                  cmd1_valid,
  output logic                  cmd1_ready,
  input  logic                  cmd1_write,
  input  logic [ADDR_WIDTH-1:0] cmd1_addr,
  input  logic [DATA_WIDTH-1:0] cmd1_wdata,
  input  logic [BYTE_WIDTH-1:0] cmd1_wstrb,
  // responses
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  // RAM ports
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_read_enable,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [BYTE_WIDTH-1:0] ram_write_enable
);

  logic r_rsp_busy;
  logic r_rsp_id;
  logic r_prio;

  logic w_rsp_hs;      // pending result taken this cycle
  logic w_slot_free;   // a new read result can be accepted
  logic w_elig0, w_elig1;
  logic w_gnt0, w_gnt1;
  logic w_gnt_any;
  logic w_sel;         // requester whose fields drive the RAM ports
  logic w_sel_write;
  logic w_new_read;

  // Slot is free when empty, or when the pending result leaves this cycle.
  always_comb begin
    w_rsp_hs    = r_rsp_busy && (r_rsp_id ? rsp1_ready : rsp0_ready);
    w_slot_free = !r_rsp_busy || w_rsp_hs;
    w_elig0     = rst_n && cmd0_valid && (cmd0_write || w_slot_free);
    w_elig1     = rst_n && cmd1_valid && (cmd1_write || w_slot_free);
  end

  // Round-robin pick between eligible requesters; prio holder wins ties.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_prio == 1'b0) begin
      w_gnt0 = w_elig0;
      w_gnt1 = w_elig1 && !w_elig0;
    end else begin
      w_gnt1 = w_elig1;
      w_gnt0 = w_elig0 && !w_elig1;
    end
    w_gnt_any   = w_gnt0 || w_gnt1;
    // With no grant the address/data buses just follow the prio requester.
    w_sel       = w_gnt1 ? 1'b1 : (w_gnt0 ? 1'b0 : r_prio);
    w_sel_write = w_sel ? cmd1_write : cmd0_write;
    w_new_read  = w_gnt_any && !w_sel_write;
  end

  // RAM port and handshake outputs.
  always_comb begin
    cmd0_ready       = w_gnt0;
    cmd1_ready       = w_gnt1;
    ram_read_addr    = w_sel ? cmd1_addr  : cmd0_addr;
    ram_write_addr   = w_sel ? cmd1_addr  : cmd0_addr;
    ram_write_data   = w_sel ? cmd1_wdata : cmd0_wdata;
    ram_read_enable  = w_new_read;
    ram_write_enable = '0;
    if (w_gnt_any && w_sel_write)
      ram_write_enable = w_sel ? cmd1_wstrb : cmd0_wstrb;
    rsp0_valid       = rst_n && r_rsp_busy && (r_rsp_id == 1'b0);
    rsp1_valid       = rst_n && r_rsp_busy && (r_rsp_id == 1'b1);
    rsp0_rdata       = ram_read_data;
    rsp1_rdata       = ram_read_data;
  end

  // Track the pending read result and rotate priority after every grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_busy <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_prio     <= 1'b0;
    end else begin
      if (w_gnt_any)
        r_prio <= ~w_sel;
      if (w_new_read) begin
        r_rsp_busy <= 1'b1;
        r_rsp_id   <= w_sel;
      end else if (w_rsp_hs) begin
        r_rsp_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed bench for dual_port_ram_arbiter with a behavioral byte-strobed RAM.
module tb_dual_port_ram_arbiter;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd0_valid, cmd0_ready, cmd0_write;
  logic [AW-1:0] cmd0_addr;
  logic [DW-1:0] cmd0_wdata;
  logic [BW-1:0] cmd0_wstrb;
  logic          cmd1_valid, cmd1_ready, cmd1_write;
  logic [AW-1:0] cmd1_addr;
  logic [DW-1:0] cmd1_wdata;
  logic [BW-1:0] cmd1_wstrb;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] ram_read_addr, ram_write_addr;
  logic          ram_read_enable;
  logic [DW-1:0] ram_read_data, ram_write_data;
  logic [BW-1:0] ram_write_enable;

  int n_chk  = 0;
  int n_pass = 0;
  int cnt0, cnt1;

  always #5 clk = ~clk;

  dual_port_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cmd0_valid(cmd0_valid), .cmd0_ready(cmd0_ready), .cmd0_write(cmd0_write),
    .cmd0_addr(cmd0_addr), .cmd0_wdata(cmd0_wdata), .cmd0_wstrb(cmd0_wstrb),
    .cmd1_valid(cmd1_valid), .cmd1_ready(cmd1_ready), .cmd1_write(cmd1_write),
    .cmd1_addr(cmd1_addr), .cmd1_wdata(cmd1_wdata), .cmd1_wstrb(cmd1_wstrb),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
    .ram_read_addr(ram_read_addr), .ram_read_enable(ram_read_enable),
    .ram_read_data(ram_read_data), .ram_write_addr(ram_write_addr),
    .ram_write_data(ram_write_data), .ram_write_enable(ram_write_enable)
  );

  // RAM: registered read that holds when not enabled, byte-strobed write.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_read_enable) ram_read_data <= mem[ram_read_addr];
    for (int b = 0; b < BW; b++)
      if (ram_write_enable[b]) mem[ram_write_addr][b*8 +: 8] <= ram_write_data[b*8 +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic c0(input logic v, input logic w, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [BW-1:0] s);
    cmd0_valid = v; cmd0_write = w; cmd0_addr = a; cmd0_wdata = d; cmd0_wstrb = s;
  endtask

  task automatic c1(input logic v, input logic w, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [BW-1:0] s);
    cmd1_valid = v; cmd1_write = w; cmd1_addr = a; cmd1_wdata = d; cmd1_wstrb = s;
  endtask

  logic [AW-1:0] b2b_addr [6] = '{8'h20, 8'h21, 8'h10, 8'h30, 8'h05, 8'h20};
  logic [DW-1:0] b2b_data [6] = '{64'hA, 64'hB, 64'h11223344556677AA, 64'h3030, 64'hDEAD, 64'hA};

  initial begin
    rst_n = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    // Reset held 3 cycles with zero-strobe writes pending on both sides.
    c0(1, 1, 8'h00, 64'h0, 8'h00);
    c1(1, 1, 8'h01, 64'h0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rst_rdy0", cmd0_ready, 0); chk("rst_rdy1", cmd1_ready, 0);
      chk("rst_we", ram_write_enable, 0); chk("rst_re", ram_read_enable, 0);
      chk("rst_rv0", rsp0_valid, 0); chk("rst_rv1", rsp1_valid, 0);
    end
    rst_n = 1'b1; #1;
    chk("first_gnt0", cmd0_ready, 1); chk("first_gnt1", cmd1_ready, 0);
    chk("zero_strb_we", ram_write_enable, 0);
    tick(); #1;
    chk("second_gnt1", cmd1_ready, 1); chk("second_gnt0", cmd0_ready, 0);

    // Full write, read back, partial write, read back.
    tick();
    c1(0, 0, 8'h00, 64'h0, 8'h00);
    c0(1, 1, 8'h10, 64'h1122334455667788, 8'hFF); #1;
    chk("wr_rdy", cmd0_ready, 1); chk("wr_we", ram_write_enable, 8'hFF);
    chk("wr_addr", ram_write_addr, 8'h10);
    tick();
    c0(1, 0, 8'h10, 64'h0, 8'h00); #1;
    chk("rd_rdy", cmd0_ready, 1); chk("rd_re", ram_read_enable, 1);
    chk("rd_we", ram_write_enable, 0);
    tick();
    c0(1, 1, 8'h10, 64'hAA, 8'h01); #1;
    chk("rd_rv0", rsp0_valid, 1); chk("rd_rv1", rsp1_valid, 0);
    chk("rd_data", rsp0_rdata, 64'h1122334455667788);
    chk("pwr_rdy", cmd0_ready, 1);
    tick();
    c0(1, 0, 8'h10, 64'h0, 8'h00); #1;
    chk("rd2_rdy", cmd0_ready, 1);
    tick();
    c0(0, 0, 8'h00, 64'h0, 8'h00);
    c1(1, 1, 8'h05, 64'hDEAD, 8'hFF); #1;
    chk("rd2_data", rsp0_rdata, 64'h11223344556677AA);
    chk("rd2_rv0", rsp0_valid, 1);
    chk("dead_wr_rdy", cmd1_ready, 1);

    // Round robin: continuous writes from both, prio now with requester 0.
    tick();
    c0(1, 1, 8'h20, 64'hA, 8'hFF);
    c1(1, 1, 8'h21, 64'hB, 8'hFF);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_gnt0", cmd0_ready, (i % 2) == 0);
      chk("rr_gnt1", cmd1_ready, (i % 2) == 1);
      if (cmd0_ready) cnt0++;
      if (cmd1_ready) cnt1++;
      tick();
    end
    chk("rr_cnt0", cnt0, 4); chk("rr_cnt1", cnt1, 4);

    // Backpressure on requester 1 while requester 0 mixes reads and writes.
    c0(0, 0, 8'h00, 64'h0, 8'h00);
    c1(1, 0, 8'h05, 64'h0, 8'h00); #1;
    chk("bp_rd1_rdy", cmd1_ready, 1);
    tick();
    c1(0, 0, 8'h00, 64'h0, 8'h00);
    rsp1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) c0(1, 0, 8'h10, 64'h0, 8'h00);
      else            c0(1, 1, 8'h30, 64'h3030, 8'hFF);
      #1;
      chk("bp_rv1", rsp1_valid, 1);
      chk("bp_data", rsp1_rdata, 64'hDEAD);
      chk("bp_rdy0", cmd0_ready, (i % 2) == 1);
      chk("bp_re", ram_read_enable, 0);
      tick();
    end
    rsp1_ready = 1'b1;
    c0(1, 0, 8'h10, 64'h0, 8'h00); #1;
    chk("bp_rel_rdy0", cmd0_ready, 1); chk("bp_rel_re", ram_read_enable, 1);
    chk("bp_rel_data", rsp1_rdata, 64'hDEAD);
    tick();
    c0(0, 0, 8'h00, 64'h0, 8'h00); #1;
    chk("bp_after_rv0", rsp0_valid, 1); chk("bp_after_rv1", rsp1_valid, 0);
    chk("bp_after_data", rsp0_rdata, 64'h11223344556677AA);

    // Back-to-back alternating reads, both response channels ready.
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        if (k % 2 == 0) begin c0(1, 0, b2b_addr[k], 64'h0, 8'h00); c1(0, 0, 8'h00, 64'h0, 8'h00); end
        else            begin c1(1, 0, b2b_addr[k], 64'h0, 8'h00); c0(0, 0, 8'h00, 64'h0, 8'h00); end
      end else begin
        c0(1, 0, 8'h10, 64'h0, 8'h00); c1(0, 0, 8'h00, 64'h0, 8'h00);
      end
      #1;
      if (k < 6) chk("b2b_rdy", (k % 2 == 0) ? cmd0_ready : cmd1_ready, 1);
      if (k > 0) begin
        chk("b2b_rv0", rsp0_valid, ((k - 1) % 2) == 0);
        chk("b2b_rv1", rsp1_valid, ((k - 1) % 2) == 1);
        chk("b2b_data", ram_read_data, b2b_data[k-1]);
      end
      tick();
    end

    // Reset while a response is stalled.
    c0(0, 0, 8'h00, 64'h0, 8'h00);
    rsp0_ready = 1'b0; #1;
    chk("mr_rv0_pre", rsp0_valid, 1);
    rst_n = 1'b0; #1;
    chk("mr_rv0_in_rst", rsp0_valid, 0);
    tick();
    rst_n = 1'b1; #1;
    chk("mr_rv0_post", rsp0_valid, 0);
    c0(1, 1, 8'h40, 64'h1, 8'hFF);
    c1(1, 1, 8'h41, 64'h2, 8'hFF); #1;
    chk("mr_prio_gnt0", cmd0_ready, 1); chk("mr_prio_gnt1", cmd1_ready, 0);
    tick();
    c0(0, 0, 8'h00, 64'h0, 8'h00);
    c1(0, 0, 8'h00, 64'h0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
